// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiplier sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_ADD = 3'b101;

  localparam int unsigned SEQ_COUNT_W = 5;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Requester-side start/done handshake of the shift-and-add multiplier.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             product_zero;

  modport master (
    output start, op_a, op_b,
    input  busy, done, product, product_zero
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, product, product_zero
  );
endinterface

// File: rtl/mul_seq_fsm.sv
// IDLE/RUN/DONE control for the multiplier; exits RUN once no multiplier
// bits remain or the 32nd step has been taken.
module mul_seq_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mplier_next_zero,
  input  logic count_last,
  output logic run,
  output logic done
);

  seq_state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEQ_IDLE;
    else       state <= state_next;
  end

  // The unused 2'b11 encoding falls into default and behaves as IDLE.
  always_comb begin
    state_next = SEQ_IDLE;
    run        = 1'b0;
    done       = 1'b0;
    case (state)
      SEQ_RUN: begin
        run        = 1'b1;
        state_next = (mplier_next_zero || count_last) ? SEQ_DONE : SEQ_RUN;
      end
      SEQ_DONE: begin
        done       = 1'b1;
        state_next = SEQ_IDLE;
      end
      default: begin
        state_next = start ? SEQ_RUN : SEQ_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add 32-bit multiplier that borrows the execute-stage ALU for
// every accumulate step instead of owning an adder.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter logic [2:0]  ALU_ADD_CODE = ALU_ADD,
  parameter int unsigned WIDTH        = 32
) (
  input  logic               clk,
  input  logic               reset,
  mul_sequencer_if.slave     bus,
  output logic               alu_own,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_result
);

  logic [WIDTH-1:0]       acc, mcand, mplier, product, acc_next;
  logic [SEQ_COUNT_W-1:0] count;
  logic                   product_zero;
  logic                   run, done, load, leave_run;
  logic                   mplier_next_zero, count_last;

  assign mplier_next_zero = (mplier[WIDTH-1:1] == '0);
  assign count_last       = (count == '1);
  assign leave_run        = mplier_next_zero || count_last;
  assign load             = bus.start && !run && !done;
  assign acc_next         = mplier[0] ? alu_result : acc;

  mul_seq_fsm u_fsm (
    .clk              (clk),
    .reset            (reset),
    .start            (bus.start),
    .mplier_next_zero (mplier_next_zero),
    .count_last       (count_last),
    .run              (run),
    .done             (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      count        <= '0;
      product      <= '0;
      product_zero <= 1'b1;
    end else if (load) begin
      acc    <= '0;
      mcand  <= bus.op_a;
      mplier <= bus.op_b;
      count  <= '0;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      // Product captures the sum including this cycle's add.
      if (leave_run) begin
        product      <= acc_next;
        product_zero <= (acc_next == '0);
      end
    end
  end

  assign alu_own     = run;
  assign alu_a       = acc;
  assign alu_b       = mcand;
  assign alu_control = run ? ALU_ADD_CODE : 3'b000;

  assign bus.busy         = run || done;
  assign bus.done         = done;
  assign bus.product      = product;
  assign bus.product_zero = product_zero;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle 32-bit integer multiplier controller that computes the low 32 bits of `op_a * op_b` by shift-and-add, borrowing the existing `ArithmeticLogicUnit` for every addition instead of owning an adder. It sits beside the ALU in the execute stage. While the sequencer runs, it claims the ALU through `alu_own`, and the datapath mux routes its operand and control lines to the ALU. Requesters use a start/done handshake; the operation terminates early once the remaining multiplier bits are zero.

## Interface
- `ALU_ADD_CODE`, default 3'b101: the `alucontrol` value that selects addition on the shared ALU.
- `WIDTH`, default 32: operand and result width; the ALU is 32 bits wide, so only 32 is supported.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op_a` in 32: multiplicand; sampled with `start`.
- `op_b` in 32: multiplier; sampled with `start`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse while in DONE.
- `product` out 32: low 32 bits of the product; held from DONE until the next accepted start.
- `product_zero` out 1: `product == 0`; registered together with `product`.
- `alu_own` out 1: high in RUN only; the datapath mux selects the sequencer's ALU inputs.
- `alu_a` out 32: accumulator, driven to the ALU `a`.
- `alu_b` out 32: shifted multiplicand, driven to the ALU `b`.
- `alu_control` out 3: `ALU_ADD_CODE` when `alu_own` is high, else 3'b000.
- `alu_result` in 32: ALU `result`; combinational within the same cycle.

## Operation
- States: IDLE, RUN, DONE. State is encoded in 2 bits; encoding 2'b11 is unreachable and decodes to IDLE.
- IDLE:
  - On `start == 1`: `mcand <= op_a`, `mplier <= op_b`, `acc <= 0`, `count <= 0`, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Drive `alu_a = acc` and `alu_b = mcand`.
  - If `mplier[0]`: `acc <= alu_result`; otherwise `acc` is unchanged.
  - `mcand <= mcand << 1`, dropping the MSB.
  - `mplier <= mplier >> 1`, shifting in zeros.
  - `count <= count + 1`; `count` is 5 bits and wraps.
  - Leave RUN when `(mplier >> 1) == 0` or `count == 31`. On exit, `product` and `product_zero` take the final accumulator value (including this cycle's add), then go to DONE.
- DONE: lasts exactly one cycle with `done = 1`, then goes to IDLE unconditionally.
- `start` in RUN or DONE is ignored, not queued. The requester must re-assert `start` in IDLE.
- Overflow above bit 31 is discarded silently. Signed and unsigned operands give identical low 32 bits.
- `reset` asserted at any time, including mid-RUN:
  - State goes to IDLE.
  - `acc`, `mcand`, `mplier`, `count`, and `product` go to 0.
  - `product_zero` goes to 1.
  - An in-flight operation is lost and `done` is not pulsed.

## Timing
- Reset values: `busy` = 0, `done` = 0, `product` = 0, `product_zero` = 1, `alu_own` = 0, `alu_a` = 0, `alu_b` = 0, `alu_control` = 3'b000.
- `start` is sampled at edge E0. RUN occupies cycles E0..E0+N-1, where N = max(1, index of the highest set bit of `op_b` + 1), so 1 ≤ N ≤ 32.
- DONE (the `done` pulse) is the cycle after E0+N-1. `product` is valid from that cycle onward.
- Total latency from `start` to `done` is N+1 cycles. The next `start` is accepted at the edge that ends DONE + 1, so back-to-back throughput is one operation per N+2 cycles.
- `alu_own`, `alu_a`, `alu_b`, and `alu_control` are decoded from registered state only, with no combinational path from `start`. The ALU path is one cycle per add: outputs to ALU to `alu_result` to the `acc` register.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU control constants (`ALU_AND` = 3'b111, `ALU_OR` = 3'b110, `ALU_ADD` = 3'b101);
  - the state enum for `mul_sequencer`.
- One natural sub-module, `mul_seq_fsm`: state register plus next-state/exit logic. It takes `start`, `mplier_next_zero`, and `count_last`, and produces `run` and `done`. The shift and accumulator registers stay in the top module.
- The ALU is not instantiated inside this block; it stays in the datapath.

## Test plan
- `op_a` = 5, `op_b` = 6, `start` for 1 cycle -> `alu_own` high for 3 cycles, `done` 4 cycles after `start`, `product` = 30, `product_zero` = 0.
- `op_a` = 0x12345678, `op_b` = 0 -> 1 RUN cycle, `done` 2 cycles after `start`, `product` = 0, `product_zero` = 1.
- `op_a` = 0xFFFFFFFF, `op_b` = 0xFFFFFFFF -> 32 RUN cycles, `done` at cycle 33, `product` = 0x00000001.
- `op_a` = 7, `op_b` = 3 in flight; pulse `start` with `op_a` = 2, `op_b` = 2 during RUN -> `product` = 21, and only one `done` pulse.
- `op_a` = 9, `op_b` = 0x80000000; assert `reset` at RUN cycle 10 -> `busy` = 0, `product` = 0, `product_zero` = 1, no `done`. After release, `op_a` = 3, `op_b` = 4 gives `product` = 12.
- `alu_control` equals 3'b101 exactly while `alu_own` = 1 and 3'b000 otherwise, checked across all of the above.
